// File: rtl/block_cost_engine.sv
// Block matching cost engine: accumulates per-row SSD/SAD between shifted left/right
// pixel windows over one block through a 3-stage pipeline, then holds the result.
module block_cost_engine #(
   parameter int  BLOCK_SIZE  = 6,
   parameter int  PIXEL_WIDTH = 8,
   parameter int  COST_MODE   = 0,
   localparam int SW          = $clog2(BLOCK_SIZE),
   localparam int COST_W      = (COST_MODE != 0 ? PIXEL_WIDTH : 2*PIXEL_WIDTH)
                                + $clog2(BLOCK_SIZE*BLOCK_SIZE)
) (
   input  logic                              clk_in,
   input  logic                              rst_in,
   input  logic                              row_valid_in,
   input  logic                              row_last_in,
   output logic                              row_ready_out,
   input  logic [SW-1:0]                     left_shift_in,
   input  logic [SW-1:0]                     right_shift_in,
   input  logic [BLOCK_SIZE*PIXEL_WIDTH-1:0] left_front_row_in,
   input  logic [BLOCK_SIZE*PIXEL_WIDTH-1:0] left_back_row_in,
   input  logic [BLOCK_SIZE*PIXEL_WIDTH-1:0] right_front_row_in,
   input  logic [BLOCK_SIZE*PIXEL_WIDTH-1:0] right_back_row_in,
   output logic                              cost_valid_out,
   input  logic                              cost_ready_in,
   output logic [COST_W-1:0]                 cost_out,
   output logic                              row_err_out
);

   localparam int unsigned N     = BLOCK_SIZE;
   localparam int unsigned W     = PIXEL_WIDTH;
   localparam int          PC_W  = (COST_MODE != 0) ? PIXEL_WIDTH : 2*PIXEL_WIDTH;
   localparam int          CNT_W = $clog2(BLOCK_SIZE+2);
   localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(BLOCK_SIZE);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_SIZE+1);

   typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [COST_W-1:0]   acc_q, acc_d;
   logic [COST_W-1:0]   cost_q, cost_d;
   logic                err_q, err_d;
   logic                s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic                s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
   logic [N*W-1:0]      lwin_q, lwin_d, rwin_q, rwin_d;
   logic [PC_W-1:0]     pc_q [N];
   logic [PC_W-1:0]     pc_d [N];
   logic [COST_W-1:0]   row_sum;
   logic                accept;

   // Window pixel i is pixel (i+s) of the 2N-pixel sequence {back, front}.
   function automatic logic [N*W-1:0] window(input logic [N*W-1:0] back,
                                             input logic [N*W-1:0] front,
                                             input logic [SW-1:0]  shift);
      logic [2*N*W-1:0] cat;
      logic [N*W-1:0]   win;
      int unsigned      s;
      cat = {back, front};
      s   = 32'(shift);
      if (s > N-1) s = N-1;
      win = '0;
      for (int unsigned i = 0; i < N; i++)
         win[(N-1-i)*W +: W] = cat[(2*N-1-i-s)*W +: W];
      return win;
   endfunction

   function automatic logic [PC_W-1:0] pixel_cost(input logic [W-1:0] l, input logic [W-1:0] r);
      logic [W-1:0]    d;
      logic [PC_W-1:0] de;
      d  = (l > r) ? l - r : r - l;
      de = PC_W'(d);
      if (COST_MODE != 0) return de;
      return de * de;
   endfunction

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      acc_d          = acc_q;
      cost_d         = cost_q;
      err_d          = err_q;
      accept         = 1'b0;
      row_ready_out  = 1'b0;
      cost_valid_out = 1'b0;

      row_sum = '0;
      for (int unsigned i = 0; i < N; i++)
         row_sum = row_sum + COST_W'(pc_q[i]);
      if (s2_valid_q) acc_d = acc_q + row_sum;

      case (state_q)
         ACCUM: begin
            row_ready_out = ~rst_in;
            accept        = row_valid_in & ~rst_in;
            if (accept) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
               if (row_last_in) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // No rows enter after the last one, so the counter is final here.
            if (s2_valid_q && s2_last_q) begin
               cost_d  = acc_q + row_sum;
               err_d   = (cnt_q != CNT_N);
               state_d = HOLD;
            end
         end
         HOLD: begin
            cost_valid_out = ~rst_in;
            if (cost_ready_in) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: state_d = ACCUM;
      endcase

      s1_valid_d = accept;
      s1_last_d  = accept & row_last_in;
      lwin_d     = window(left_back_row_in, left_front_row_in, left_shift_in);
      rwin_d     = window(right_back_row_in, right_front_row_in, right_shift_in);
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      for (int unsigned i = 0; i < N; i++)
         pc_d[i] = pixel_cost(lwin_q[(N-1-i)*W +: W], rwin_q[(N-1-i)*W +: W]);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= ACCUM;
         cnt_q      <= '0;
         acc_q      <= '0;
         cost_q     <= '0;
         err_q      <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         cost_q     <= cost_d;
         err_q      <= err_d;
         s1_valid_q <= s1_valid_d;
         s1_last_q  <= s1_last_d;
         s2_valid_q <= s2_valid_d;
         s2_last_q  <= s2_last_d;
      end
   end

   always_ff @(posedge clk_in) begin
      lwin_q <= lwin_d;
      rwin_q <= rwin_d;
      pc_q   <= pc_d;
   end

   assign cost_out    = rst_in ? '0 : cost_q;
   assign row_err_out = rst_in ? 1'b0 : err_q;

endmodule

// File: tb/tb_block_cost_engine.sv
// Scoreboard bench for block_cost_engine: one SSD and one SAD instance share stimulus;
// expected block costs are queued at last-row acceptance and checked when the cost appears.
module tb_block_cost_engine;

   localparam int N = 6;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          row_valid = 1'b0, row_last = 1'b0, cost_ready = 1'b0;
   logic [2:0]    ls = '0, rs = '0;
   logic [47:0]   lf = '0, lb = '0, rf = '0, rb = '0;
   logic          ready0, ready1, cval0, cval1, err0, err1;
   logic [21:0]   cost0;
   logic [13:0]   cost1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [63:0] ssd;
      logic [63:0] sad;
      logic        err;
      int          acc_cyc;
   } exp_t;
   exp_t exp_q[$];

   logic [63:0] run_ssd = '0, run_sad = '0;
   int          run_rows = 0;

   block_cost_engine #(.BLOCK_SIZE(6), .PIXEL_WIDTH(8), .COST_MODE(0)) dut0 (
      .clk_in(clk), .rst_in(rst), .row_valid_in(row_valid), .row_last_in(row_last),
      .row_ready_out(ready0), .left_shift_in(ls), .right_shift_in(rs),
      .left_front_row_in(lf), .left_back_row_in(lb), .right_front_row_in(rf),
      .right_back_row_in(rb), .cost_valid_out(cval0), .cost_ready_in(cost_ready),
      .cost_out(cost0), .row_err_out(err0));

   block_cost_engine #(.BLOCK_SIZE(6), .PIXEL_WIDTH(8), .COST_MODE(1)) dut1 (
      .clk_in(clk), .rst_in(rst), .row_valid_in(row_valid), .row_last_in(row_last),
      .row_ready_out(ready1), .left_shift_in(ls), .right_shift_in(rs),
      .left_front_row_in(lf), .left_back_row_in(lb), .right_front_row_in(rf),
      .right_back_row_in(rb), .cost_valid_out(cval1), .cost_ready_in(cost_ready),
      .cost_out(cost1), .row_err_out(err1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int pix(input logic [47:0] back, input logic [47:0] front,
                              input int s, input int i);
      int j;
      j = i + s;
      if (j < N) return int'(back[(N-1-j)*W +: W]);
      return int'(front[(N-1-(j-N))*W +: W]);
   endfunction

   function automatic logic [63:0] row_cost(input logic [47:0] b_l, input logic [47:0] f_l,
                                            input logic [2:0] sh_l, input logic [47:0] b_r,
                                            input logic [47:0] f_r, input logic [2:0] sh_r,
                                            input bit sad);
      int sl, sr, a, b, d;
      logic [63:0] sum;
      sl  = (int'(sh_l) > N-1) ? N-1 : int'(sh_l);
      sr  = (int'(sh_r) > N-1) ? N-1 : int'(sh_r);
      sum = '0;
      for (int i = 0; i < N; i++) begin
         a = pix(b_l, f_l, sl, i);
         b = pix(b_r, f_r, sr, i);
         d = (a > b) ? a - b : b - a;
         sum = sum + (sad ? 64'(d) : 64'(d * d));
      end
      return sum;
   endfunction

   function automatic logic [47:0] rnd48();
      return {$urandom(), $urandom()} >> 16;
   endfunction

   task automatic drive_garbage();
      row_valid = 1'b1;
      row_last  = 1'($urandom_range(0, 1));
      lf = rnd48(); lb = rnd48(); rf = rnd48(); rb = rnd48();
      ls = 3'($urandom_range(0, 7)); rs = 3'($urandom_range(0, 7));
   endtask

   task automatic send_row(input logic [47:0] b_l, input logic [47:0] f_l, input logic [2:0] sh_l,
                           input logic [47:0] b_r, input logic [47:0] f_r, input logic [2:0] sh_r,
                           input bit last);
      int n;
      int acc_t;
      exp_t e;
      @(negedge clk);
      lb = b_l; lf = f_l; ls = sh_l; rb = b_r; rf = f_r; rs = sh_r;
      row_valid  = 1'b1;
      row_last   = last;
      cost_ready = 1'($urandom_range(0, 1));
      n = 0;
      while (ready0 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (ready0 !== 1'b1) begin
         total++; bad++;
         $display("FAIL row_accept: row_ready_out=%b required 1 within 20 cycles", ready0);
         row_valid = 1'b0;
         return;
      end
      acc_t = cyc;
      @(posedge clk);
      run_ssd  = run_ssd + row_cost(b_l, f_l, sh_l, b_r, f_r, sh_r, 1'b0);
      run_sad  = run_sad + row_cost(b_l, f_l, sh_l, b_r, f_r, sh_r, 1'b1);
      run_rows = run_rows + 1;
      if (last) begin
         e.ssd = run_ssd; e.sad = run_sad; e.err = (run_rows != N); e.acc_cyc = acc_t;
         exp_q.push_back(e);
         run_ssd = '0; run_sad = '0; run_rows = 0;
      end
   endtask

   task automatic send_block(input int nrows);
      for (int r = 0; r < nrows; r++)
         send_row(rnd48(), rnd48(), 3'($urandom_range(0, 7)),
                  rnd48(), rnd48(), 3'($urandom_range(0, 7)), r == nrows - 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_garbage();
      @(negedge clk);
      total++;
      if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
         bad++; $display("FAIL rst_ready: got %b/%b required 0", ready0, ready1);
      end
      total++;
      if (cval0 !== 1'b0 || cval1 !== 1'b0) begin
         bad++; $display("FAIL rst_cost_valid: got %b/%b required 0", cval0, cval1);
      end
      total++;
      if (cost0 !== 22'd0 || cost1 !== 14'd0) begin
         bad++; $display("FAIL rst_cost: got %0d/%0d required 0", cost0, cost1);
      end
      total++;
      if (err0 !== 1'b0 || err1 !== 1'b0) begin
         bad++; $display("FAIL rst_err: got %b/%b required 0", err0, err1);
      end
      rst = 1'b0;
      row_valid = 1'b0;
      cost_ready = 1'b0;
      run_ssd = '0; run_sad = '0; run_rows = 0;
      exp_q.delete();
      @(negedge clk);
      total++;
      if (ready0 !== 1'b1 || ready1 !== 1'b1 || cval0 !== 1'b0) begin
         bad++; $display("FAIL rst_release: ready=%b/%b cost_valid=%b required 1/1/0", ready0, ready1, cval0);
      end
   endtask

   task automatic wait_cost(input int hold_n, input bit rst_in_hold);
      bit   seen;
      exp_t e;
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (cval0 === 1'b1) begin
            seen = 1'b1;
            break;
         end
         drive_garbage();
         cost_ready = 1'($urandom_range(0, 1));
      end
      cost_ready = 1'b0;
      if (!seen) begin
         total++; bad++;
         $display("FAIL cost_timeout: cost_valid_out=%b required 1 within 20 cycles", cval0);
         row_valid = 1'b0;
         return;
      end
      if (exp_q.size() == 0) begin
         total++; bad++;
         $display("FAIL cost_unexpected: cost_valid_out=1 with no block pending");
         return;
      end
      e = exp_q.pop_front();
      total++;
      if (cyc - e.acc_cyc != 3) begin
         bad++; $display("FAIL latency: got %0d cycles required 3", cyc - e.acc_cyc);
      end
      total++;
      if (cost0 !== e.ssd[21:0]) begin
         bad++; $display("FAIL ssd_cost: got %0d required %0d", cost0, e.ssd);
      end
      total++;
      if (cval1 !== 1'b1 || cost1 !== e.sad[13:0]) begin
         bad++; $display("FAIL sad_cost: valid=%b got %0d required %0d", cval1, cost1, e.sad);
      end
      total++;
      if (err0 !== e.err || err1 !== e.err) begin
         bad++; $display("FAIL row_err: got %b/%b required %b", err0, err1, e.err);
      end
      for (int k = 0; k < hold_n; k++) begin
         drive_garbage();
         @(negedge clk);
         total++;
         if (cval0 !== 1'b1 || ready0 !== 1'b0 || cost0 !== e.ssd[21:0] || err0 !== e.err) begin
            bad++;
            $display("FAIL hold_%0d: valid=%b ready=%b cost=%0d err=%b required 1/0/%0d/%b",
                     k, cval0, ready0, cost0, err0, e.ssd, e.err);
         end
      end
      if (rst_in_hold) begin
         do_reset();
         return;
      end
      cost_ready = 1'b1;
      row_valid  = 1'b0;
      @(negedge clk);
      cost_ready = 1'b0;
      total++;
      if (ready0 !== 1'b1 || cval0 !== 1'b0) begin
         bad++; $display("FAIL handshake: ready=%b valid=%b required 1/0", ready0, cval0);
      end
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_zero_cost();
      logic [47:0] r;
      for (int i = 0; i < N; i++) begin
         r = rnd48();
         send_row(r, rnd48(), 3'd0, r, rnd48(), 3'd0, i == N - 1);
      end
      wait_cost(0, 1'b0);
   endtask

   task automatic test_const_diff();
      for (int i = 0; i < N; i++)
         send_row({6{8'd10}}, {6{8'd10}}, 3'($urandom_range(0, 7)),
                  {6{8'd7}}, {6{8'd7}}, 3'($urandom_range(0, 7)), i == N - 1);
      wait_cost(0, 1'b0);
      for (int i = 0; i < N; i++)
         send_row({6{8'd255}}, {6{8'd255}}, 3'd0, {6{8'd0}}, {6{8'd0}}, 3'd5, i == N - 1);
      wait_cost(0, 1'b0);
   endtask

   task automatic test_shift();
      for (int i = 0; i < N; i++)
         send_row(48'h01_02_03_04_05_06, 48'h07_08_09_0a_0b_0c, 3'd2,
                  48'h03_04_05_06_07_08, rnd48(), 3'd0, i == N - 1);
      wait_cost(0, 1'b0);
      for (int i = 0; i < N; i++)
         send_row(rnd48(), rnd48(), 3'(5 + (i % 3)), rnd48(), rnd48(), 3'(i + 2), i == N - 1);
      wait_cost(1, 1'b0);
   endtask

   task automatic test_hold();
      send_block(N);
      wait_cost(5, 1'b0);
   endtask

   task automatic test_row_count();
      send_block(4);
      wait_cost(0, 1'b0);
      send_block(7);
      wait_cost(0, 1'b0);
      send_block(1);
      wait_cost(2, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++)
         send_row({6{8'd200}}, rnd48(), 3'd0, {6{8'd1}}, rnd48(), 3'd0, 1'b0);
      do_reset();
      send_block(N);
      wait_cost(0, 1'b0);
      send_block(N);
      wait_cost(2, 1'b1);
      send_block(N);
      wait_cost(0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int b = 0; b < 4; b++) begin
         send_block(N);
         wait_cost(int'($urandom_range(0, 2)), 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_zero_cost();
      test_const_diff();
      test_shift();
      test_hold();
      test_row_count();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/block_cost_engine.md
BLOCK_COST_ENGINE -- requirements
Module: block_cost_engine

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 6: block edge length N in pixels, range 2..16.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8: bits per pixel, W.
REQ-003 SHALL have parameter COST_MODE, default 0: 0 = sum of squared differences (SSD), 1 = sum of absolute differences (SAD).
REQ-004 SHALL define localparams SW = $clog2(N) and COST_W = (COST_MODE ? W : 2*W) + $clog2(N*N); the default COST_W is 22.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port row_valid_in, input, 1 bit: a block row is presented.
REQ-008 SHALL have port row_last_in, input, 1 bit: the presented row is the final row of the block.
REQ-009 SHALL have port row_ready_out, output, 1 bit: the engine accepts a row this cycle.
REQ-010 SHALL have ports left_shift_in and right_shift_in, input, SW bits each: column offset s of the block within the front/back buffer pair.
REQ-011 SHALL have ports left_front_row_in, left_back_row_in, right_front_row_in and right_back_row_in, input, N*W bits each; pixel 0 sits in the most significant W bits.
REQ-012 SHALL have port cost_valid_out, output, 1 bit: block cost available.
REQ-013 SHALL have port cost_ready_in, input, 1 bit: consumer takes the cost.
REQ-014 SHALL have port cost_out, output, COST_W bits: accumulated block cost.
REQ-015 SHALL have port row_err_out, output, 1 bit: the block's row count was not N; qualified by cost_valid_out.

Function
REQ-016 SHALL accept a row on any cycle in which row_valid_in and row_ready_out are both high.
REQ-017 SHALL form the window for shift s as {back[(N-s)*W-1:0], front[N*W-1:(N-s)*W]}; s=0 selects back unchanged.
REQ-018 SHALL saturate a shift value greater than N-1 to N-1.
REQ-019 SHALL compute, per pixel, the unsigned difference d = |L-R|, then cost d*d in SSD mode or d in SAD mode.
REQ-020 SHALL sum the N pixel costs of a row and add the sum to the block accumulator; no arithmetic overflow is possible at COST_W.
REQ-021 SHALL use a 3-stage pipeline: S1 registers the windows, S2 registers the per-pixel costs, S3 registers the row sum and the accumulator update.
REQ-022 SHALL implement FSM states ACCUM, DRAIN and HOLD; the reset state is ACCUM.
REQ-023 In ACCUM, SHALL drive row_ready_out=1; on accepting a row with row_last_in=1, SHALL go to DRAIN.
REQ-024 In DRAIN, SHALL drive row_ready_out=0 and wait until the last row exits S3, then load cost_out and row_err_out and go to HOLD.
REQ-025 SHALL assert cost_valid_out exactly 3 cycles after the cycle in which the last row is accepted.
REQ-026 In HOLD, SHALL keep cost_valid_out=1 and cost_out/row_err_out stable and drive row_ready_out=0, until cost_ready_in=1.
REQ-027 On the HOLD handshake, SHALL clear the accumulator and row counter and return to ACCUM, with row_ready_out=1 on the next cycle.
REQ-028 SHALL count accepted rows per block; row_err_out=1 if the last row is the k-th accepted row with k≠N.
REQ-029 SHALL, on acceptance of an (N+1)-th row without row_last_in, keep accumulating, saturate the row counter and flag the error.
REQ-030 SHALL ignore row_valid_in while row_ready_out=0; rows presented then are not accumulated.
REQ-031 SHALL ignore cost_ready_in outside HOLD.

Reset
REQ-032 While rst_in=1, SHALL drive row_ready_out=0, cost_valid_out=0, cost_out=0 and row_err_out=0, and SHALL clear the FSM (to ACCUM), the pipeline valids, the accumulator and the row counter.
REQ-033 SHALL discard any partially accumulated block or held cost on reset; row_ready_out=1 on the first cycle after rst_in falls.

Verification
REQ-034 SHALL pass: defaults, 6 identical rows, shifts 0 -> cost_out=0, row_err_out=0, cost_valid_out 3 cycles after the last row.
REQ-035 SHALL pass: SSD, left pixels all 10, right all 7, 6 rows -> cost_out=324; the same with COST_MODE=1 -> 108; left 255, right 0, SSD -> 2340900.
REQ-036 SHALL pass: left back pixels 1..6, front 7..12, left_shift_in=2, right window equal to the expected {3,4,5,6,7,8} -> cost_out=0.
REQ-037 SHALL pass: cost_ready_in held low 5 cycles after cost_valid_out -> cost_out stable and row_ready_out=0 for all 5; handshake -> row_ready_out=1 next cycle.
REQ-038 SHALL pass: row_last_in on the 4th row -> row_err_out=1 and cost_out equal to the sum over those 4 rows; 7 rows -> row_err_out=1.
REQ-039 SHALL pass: rst_in pulsed after 3 rows -> outputs zeroed; a following clean 6-row block gives the correct cost with no carry-over.
